led_scan_controller: RTL and testbench

Time-multiplexing scheduler for the 8-digit seven-segment channel. It generates the 3-bit digit-select sequence at a fixed refresh rate and inserts an anti-ghosting blank interval at the start of each digit slot. It also arbitrates display ownership between two requesters (A and B). The winner's 32-bit word is loaded into a shadow register only at frame boundaries, so a frame never tears. It sits between the processor debug/IO logic and the seven-segment decoder.

---
 rtl/led_scan_controller.sv | 126 ++++++++++++
 tb/tb_led_scan_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// rtl/led_scan_controller.sv - 8-digit seven-segment scan scheduler with frame-aligned A/B display arbitration.
// Optional LED_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module led_scan_controller #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [2:0]  scan_sel,
  output logic [31:0] disp_data,
  output logic        disp_on,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic             RR_A       = 1'b0;
  localparam logic             RR_B       = 1'b1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        scan_sel_q, scan_sel_d;
  logic [31:0]       disp_data_q, disp_data_d;
  logic              disp_on_q, disp_on_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              frame_tick_q, frame_tick_d;
  logic              rr_last_q, rr_last_d;

  logic              wrap;
  logic              boundary;
  logic              win_a;
  logic              win_b;
  logic              digit_lit;

`ifdef LED_LEADING_ZERO_BLANK_EN
  function automatic logic [2:0] top_digit(input logic [31:0] word);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (word[4*i +: 4] != 4'h0) idx = 3'(i);
    end
    return idx;
  endfunction
`endif

  always_comb begin
    wrap       = (cnt_q == LAST_CNT);
    boundary   = wrap && (scan_sel_q == 3'd7);
    cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
    scan_sel_d = wrap ? scan_sel_q + 3'd1 : scan_sel_q;

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (wrap) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    // A tie goes to whichever requester did not win the previous tie.
    win_a = boundary && req_a && (!req_b || (rr_last_q == RR_B));
    win_b = boundary && req_b && !win_a;

    rr_last_d = rr_last_q;
    if (req_a && req_b && boundary) rr_last_d = win_a ? RR_A : RR_B;

    disp_data_d = disp_data_q;
    if (win_a) disp_data_d = data_a;
    else if (win_b) disp_data_d = data_b;

    gnt_a_d      = win_a;
    gnt_b_d      = win_b;
    frame_tick_d = (cnt_d == LAST_CNT) && (scan_sel_d == 3'd7);

`ifdef LED_LEADING_ZERO_BLANK_EN
    digit_lit = (scan_sel_d <= top_digit(disp_data_d));
`else
    digit_lit = 1'b1;
`endif
    disp_on_d = (state_d == ST_SHOW) && digit_lit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      scan_sel_q   <= 3'd0;
      disp_data_q  <= 32'h0;
      disp_on_q    <= 1'b0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      rr_last_q    <= RR_B;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_sel_q   <= scan_sel_d;
      disp_data_q  <= disp_data_d;
      disp_on_q    <= disp_on_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      frame_tick_q <= frame_tick_d;
      rr_last_q    <= rr_last_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign scan_sel   = scan_sel_q;
  assign disp_data  = disp_data_q;
  assign disp_on    = disp_on_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// tb/tb_led_scan_controller.sv - randomized scoreboard bench for led_scan_controller (SCAN_DIV=8, BLANK_CYC=2).
module tb_led_scan_controller;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] data_a = 32'h0, data_b = 32'h0;
  logic        gnt_a, gnt_b, disp_on, frame_tick;
  logic [2:0]  scan_sel;
  logic [31:0] disp_data;

  always #5 clk = ~clk;

  led_scan_controller #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(17)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .scan_sel(scan_sel),
    .disp_data(disp_data), .disp_on(disp_on), .frame_tick(frame_tick)
  );

  typedef struct {
    int          t;
    logic [2:0]  sel;
    logic        on;
    logic        tick;
    logic        ga;
    logic        gb;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        who_b;
    logic [31:0] data;
  } gnt_t;

  exp_t exp_q[$];
  gnt_t gnt_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          t;
  logic [31:0] m_disp;
  logic        m_rr_b;
  logic        pend_a, pend_b;
  int          drop_a_at, drop_b_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int top_digit(input logic [31:0] d);
    int k;
    k = 0;
    while (k < 7 && (d >> (4 * (k + 1))) != 0) k++;
    return k;
  endfunction

  function automatic logic [31:0] rnd_word();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h00000A05;
    if (r == 1) return 32'h0;
    return $urandom >> (4 * $urandom_range(0, 7));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    gnt_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scan_sel",   {29'b0, scan_sel},   {29'b0, e.sel},  e.t);
      chk("disp_on",    {31'b0, disp_on},    {31'b0, e.on},   e.t);
      chk("frame_tick", {31'b0, frame_tick}, {31'b0, e.tick}, e.t);
      chk("gnt_a",      {31'b0, gnt_a},      {31'b0, e.ga},   e.t);
      chk("gnt_b",      {31'b0, gnt_b},      {31'b0, e.gb},   e.t);
      chk("disp_data",  disp_data,           e.data,          e.t);
    end
    if (!rst && (gnt_a || gnt_b)) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected_grant", 32'd1, 32'd0, e.t);
      end else begin
        g = gnt_q.pop_front();
        chk("grant_owner", {31'b0, gnt_b}, {31'b0, g.who_b}, e.t);
        chk("grant_word",  disp_data,      g.data,           e.t);
      end
    end
  end

  task automatic model_reset();
    t         = 0;
    m_disp    = 32'h0;
    m_rr_b    = 1'b1;
    pend_a    = 1'b0;
    pend_b    = 1'b0;
    drop_a_at = -1;
    drop_b_at = -1;
  endtask

  task automatic do_cycle(input int p_req);
    exp_t e;
    gnt_t g;
    int   cnt;
    logic win_a, win_b;

    if (t == drop_a_at) req_a = 1'b0;
    else if (!req_a && $urandom_range(0, 99) < p_req) begin
      req_a  = 1'b1;
      data_a = rnd_word();
    end
    if (t == drop_b_at) req_b = 1'b0;
    else if (!req_b && $urandom_range(0, 99) < p_req) begin
      req_b  = 1'b1;
      data_b = rnd_word();
    end

    cnt    = t % SD;
    e.t    = t;
    e.sel  = 3'((t / SD) % 8);
    e.tick = ((t % FRAME) == FRAME - 1);
    e.on   = (cnt >= BC);
`ifdef LED_LEADING_ZERO_BLANK_EN
    if (int'(e.sel) > top_digit(m_disp)) e.on = 1'b0;
`endif
    e.ga   = pend_a;
    e.gb   = pend_b;
    e.data = m_disp;
    exp_q.push_back(e);
    pend_a = 1'b0;
    pend_b = 1'b0;

    if (e.tick) begin
      win_a = 1'b0;
      win_b = 1'b0;
      if (req_a && req_b) begin
        if (m_rr_b) win_a = 1'b1;
        else win_b = 1'b1;
        m_rr_b = win_b;
      end else if (req_a) win_a = 1'b1;
      else if (req_b) win_b = 1'b1;
      if (win_a) begin
        m_disp = data_a; pend_a = 1'b1; drop_a_at = t + 2;
      end
      if (win_b) begin
        m_disp = data_b; pend_b = 1'b1; drop_b_at = t + 2;
      end
      if (win_a || win_b) begin
        g.who_b = win_b;
        g.data  = m_disp;
        gnt_q.push_back(g);
      end
    end

    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    repeat (2 * FRAME) do_cycle(0);
    repeat (4 * FRAME) do_cycle(100);
    repeat (10 * FRAME) do_cycle(3);
    repeat (FRAME) do_cycle(20);
    while ((t % FRAME) != 30) do_cycle(20);

    // Asynchronous reset mid-SHOW: outputs must clear without a clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_scan_sel",   {29'b0, scan_sel},   32'd0, -1);
    chk("rst_disp_on",    {31'b0, disp_on},    32'd0, -1);
    chk("rst_disp_data",  disp_data,           32'd0, -1);
    chk("rst_frame_tick", {31'b0, frame_tick}, 32'd0, -1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    repeat (3 * FRAME) do_cycle(100);
    repeat (4 * FRAME) do_cycle(5);
    while ((t % FRAME) != 10) do_cycle(5);

    @(negedge clk);
    #1;
    chk("exp_queue_drained",   32'(exp_q.size()), 32'd0, t);
    chk("grant_queue_drained", 32'(gnt_q.size()), 32'd0, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
